// File: rtl/i2s_sample_rx.sv
// I2S stereo receiver: oversamples SCK/WS/SD in the clk domain and emits
// DATA_WIDTH-bit left/right samples with a valid pulse and a frame strobe.
module i2s_sample_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck_in,
   input  logic                  ws_in,
   input  logic                  sd_in,
   output logic [DATA_WIDTH-1:0] left_out,
   output logic [DATA_WIDTH-1:0] right_out,
   output logic                  sample_valid,
   output logic                  sample_clk,
   output logic                  short_err
);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic {ALIGN, RUN} state_t;
   state_t state;

   logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
   logic                   sck_s, sck_d, rise_q, ws_q, sd_q;
   logic                   ws_prev, have_prev, lcommit_q;
   logic [DATA_WIDTH-1:0]  shift, stage, sh_nx, word;
   logic [CW-1:0]          cnt, cnt_nx;

   assign sck_s = sck_sync[SYNC_STAGES-1];

   // Equal-depth chains keep SCK, WS and SD mutually aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync <= '0;
         ws_sync  <= '0;
         sd_sync  <= '0;
         sck_d    <= 1'b0;
         rise_q   <= 1'b0;
         ws_q     <= 1'b0;
         sd_q     <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
         ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_in};
         sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_in};
         sck_d    <= sck_s;
         rise_q   <= sck_s & ~sck_d;
         ws_q     <= ws_sync[SYNC_STAGES-1];
         sd_q     <= sd_sync[SYNC_STAGES-1];
      end
   end

   // Append the current bit (saturating) and left-justify for a possible commit.
   always_comb begin
      sh_nx  = shift;
      cnt_nx = cnt;
      if (cnt < CW'(DATA_WIDTH)) begin
         sh_nx  = {shift[DATA_WIDTH-2:0], sd_q};
         cnt_nx = cnt + 1'b1;
      end
      word = sh_nx << (CW'(DATA_WIDTH) - cnt_nx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ALIGN;
         shift        <= '0;
         cnt          <= '0;
         stage        <= '0;
         ws_prev      <= 1'b0;
         have_prev    <= 1'b0;
         lcommit_q    <= 1'b0;
         left_out     <= '0;
         right_out    <= '0;
         sample_valid <= 1'b0;
         sample_clk   <= 1'b0;
         short_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         lcommit_q    <= 1'b0;
         if (state == RUN) begin
            if (sample_valid)   sample_clk <= 1'b1;
            else if (lcommit_q) sample_clk <= 1'b0;
         end
         if (rise_q) begin
            ws_prev   <= ws_q;
            have_prev <= 1'b1;
            // The first rise only seeds ws_prev so a mid-word start cannot align.
            if (state == ALIGN) begin
               if (have_prev && (ws_q != ws_prev)) begin
                  state <= RUN;
                  shift <= '0;
                  cnt   <= '0;
               end
            end else if (ws_q == ws_prev) begin
               shift <= sh_nx;
               cnt   <= cnt_nx;
            end else begin
               shift <= '0;
               cnt   <= '0;
               if (cnt_nx < CW'(DATA_WIDTH)) short_err <= 1'b1;
               if (!ws_prev) begin
                  stage     <= word;
                  lcommit_q <= 1'b1;
               end else begin
                  right_out    <= word;
                  left_out     <= stage;
                  sample_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench for i2s_sample_rx: drives I2S frames at SCK = clk/4 and
// checks committed samples, error flag and frame-strobe timing.
module tb_i2s_sample_rx;
   logic        clk = 1'b0, rst = 1'b1;
   logic        sck_in = 1'b0, ws_in = 1'b0, sd_in = 1'b0;
   logic [15:0] left_out, right_out;
   logic        sample_valid, sample_clk, short_err;

   int n_cmp = 0, n_fail = 0;
   int phase = 2;

   i2s_sample_rx #(.SYNC_STAGES(2), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .sck_in(sck_in), .ws_in(ws_in), .sd_in(sd_in),
      .left_out(left_out), .right_out(right_out), .sample_valid(sample_valid),
      .sample_clk(sample_clk), .short_err(short_err)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: time limit reached, required finish before 3ms");
      $fatal(1, "watchdog");
   end

   // Monitor: logs valid pulses and sample_clk edges, sampled on negedge.
   typedef struct packed {logic [15:0] l; logic [15:0] r;} pulse_t;
   pulse_t pq[$];
   int periods[$], highs[$];
   int cyc = 0, rise_cyc = 0, vld_run = 0, vld_maxrun = 0;
   bit have_rise = 0, sc_prev = 0;

   always @(negedge clk) begin
      cyc++;
      if (sample_valid) begin
         pq.push_back({left_out, right_out});
         vld_run++;
         if (vld_run > vld_maxrun) vld_maxrun = vld_run;
      end else vld_run = 0;
      if (sample_clk && !sc_prev) begin
         if (have_rise) periods.push_back(cyc - rise_cyc);
         rise_cyc  = cyc;
         have_rise = 1;
      end
      if (!sample_clk && sc_prev && have_rise) highs.push_back(cyc - rise_cyc);
      sc_prev = sample_clk;
   end

   task automatic clear_mon();
      pq.delete();
      periods.delete();
      highs.delete();
      have_rise  = 0;
      vld_maxrun = 0;
   endtask

   function automatic logic getbit(input logic [31:0] w, input int bits, input int j);
      if (j < bits) return w[bits-1-j];
      return 1'b0;
   endfunction

   task automatic idle(input int n);
      sck_in = 1'b0;
      repeat (n) @(posedge clk);
      #(phase);
   endtask

   task automatic send_bit(input logic ws, input logic sd);
      sck_in = 1'b0;
      ws_in  = ws;
      sd_in  = sd;
      #20;
      sck_in = 1'b1;
      #20;
   endtask

   // Slot position 0 carries the LSB slot of the previous channel (one-bit WS lead).
   task automatic send_slot(input logic ch, input logic [31:0] w, input logic [31:0] pw,
                            input int bits, input int slot, input int k0, input int k1);
      for (int k = k0; k < k1; k++)
         send_bit(ch, (k == 0) ? getbit(pw, bits, slot - 1) : getbit(w, bits, k - 1));
   endtask

   task automatic send_frames(input int n, input logic [31:0] l, input logic [31:0] r,
                              input logic [31:0] pw, input int bits, input int slot);
      logic [31:0] p;
      p = pw;
      for (int f = 0; f < n; f++) begin
         send_slot(1'b0, l, p, bits, slot, 0, slot);
         send_slot(1'b1, r, l, bits, slot, 0, slot);
         p = r;
      end
   endtask

   task automatic send_tail(input logic [31:0] r, input int bits, input int slot);
      send_slot(1'b0, 32'h0, r, bits, slot, 0, 1);
      idle(20);
   endtask

   task automatic do_reset();
      sck_in = 1'b0;
      ws_in  = 1'b0;
      sd_in  = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_mon();
      idle(4);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({left_out, right_out, sample_valid, sample_clk, short_err} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_state: got L=%h R=%h v=%b sc=%b se=%b, required all 0",
                  left_out, right_out, sample_valid, sample_clk, short_err);
      end
      rst = 1'b0;
      clear_mon();
      idle(4);
   endtask

   task automatic test_frames16();
      do_reset();
      send_frames(4, 32'h1234, 32'hABCD, 32'hABCD, 16, 16);
      send_tail(32'hABCD, 16, 16);
      n_cmp++;
      if (pq.size() != 4) begin
         n_fail++;
         $display("FAIL f16_pulse_count: got %0d, required 4", pq.size());
      end
      n_cmp++;
      if (pq.size() > 0 && pq[0] !== {16'h0000, 16'hABCD}) begin
         n_fail++;
         $display("FAIL f16_first_pulse: got %h, required 0000abcd", pq[0]);
      end
      for (int i = 1; i < pq.size(); i++) begin
         n_cmp++;
         if (pq[i] !== {16'h1234, 16'hABCD}) begin
            n_fail++;
            $display("FAIL f16_pulse%0d: got %h, required 1234abcd", i, pq[i]);
         end
      end
      n_cmp++;
      if (vld_maxrun != 1) begin
         n_fail++;
         $display("FAIL f16_valid_width: got %0d cycles, required 1", vld_maxrun);
      end
      n_cmp++;
      if (short_err !== 1'b0) begin
         n_fail++;
         $display("FAIL f16_short_err: got %b, required 0", short_err);
      end
   endtask

   task automatic test_slot24();
      do_reset();
      send_frames(2, 32'h7FFF00, 32'h800001, 32'h800001, 24, 32);
      send_tail(32'h800001, 24, 32);
      n_cmp++;
      if (pq.size() != 2 || pq[pq.size()-1] !== {16'h7FFF, 16'h8000}) begin
         n_fail++;
         $display("FAIL s24_truncate: got n=%0d last=%h, required n=2 last=7fff8000",
                  pq.size(), (pq.size() > 0) ? pq[pq.size()-1] : 32'h0);
      end
      n_cmp++;
      if (short_err !== 1'b0) begin
         n_fail++;
         $display("FAIL s24_short_err: got %b, required 0", short_err);
      end
   endtask

   task automatic test_short12();
      do_reset();
      send_frames(2, 32'hABC, 32'h123, 32'h123, 12, 12);
      send_tail(32'h123, 12, 12);
      n_cmp++;
      if (pq.size() != 2 || pq[pq.size()-1] !== {16'hABC0, 16'h1230}) begin
         n_fail++;
         $display("FAIL w12_justify: got n=%0d last=%h, required n=2 last=abc01230",
                  pq.size(), (pq.size() > 0) ? pq[pq.size()-1] : 32'h0);
      end
      n_cmp++;
      if (short_err !== 1'b1) begin
         n_fail++;
         $display("FAIL w12_short_err_set: got %b, required 1", short_err);
      end
      idle(40);
      n_cmp++;
      if (short_err !== 1'b1 || left_out !== 16'hABC0) begin
         n_fail++;
         $display("FAIL w12_sticky_hold: got se=%b L=%h, required se=1 L=abc0", short_err, left_out);
      end
      do_reset();
      n_cmp++;
      if (short_err !== 1'b0) begin
         n_fail++;
         $display("FAIL w12_short_err_clear: got %b, required 0", short_err);
      end
   endtask

   task automatic test_midword();
      do_reset();
      for (int i = 0; i < 8; i++) send_bit(1'b1, i[0]);
      send_frames(1, 32'h5A5A, 32'hC3C3, 32'h0, 16, 16);
      n_cmp++;
      if (pq.size() != 0) begin
         n_fail++;
         $display("FAIL mid_no_early_pulse: got %0d pulses, required 0", pq.size());
      end
      send_tail(32'hC3C3, 16, 16);
      n_cmp++;
      if (pq.size() != 1 || pq[0] !== {16'h5A5A, 16'hC3C3}) begin
         n_fail++;
         $display("FAIL mid_first_pulse: got n=%0d first=%h, required n=1 first=5a5ac3c3",
                  pq.size(), (pq.size() > 0) ? pq[0] : 32'h0);
      end
   endtask

   task automatic test_rst_midword();
      do_reset();
      send_frames(2, 32'h1111, 32'h2222, 32'h2222, 16, 16);
      send_slot(1'b0, 32'h3333, 32'h2222, 16, 16, 0, 8);
      sck_in = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++;
      if (pq.size() != 2 || left_out !== 16'h1111 || right_out !== 16'h2222) begin
         n_fail++;
         $display("FAIL rst_pre: got n=%0d L=%h R=%h, required n=2 L=1111 R=2222",
                  pq.size(), left_out, right_out);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({left_out, right_out, sample_valid, sample_clk, short_err} !== 35'h0) begin
         n_fail++;
         $display("FAIL rst_during: got L=%h R=%h v=%b sc=%b se=%b, required all 0",
                  left_out, right_out, sample_valid, sample_clk, short_err);
      end
      @(negedge clk) rst = 1'b0;
      clear_mon();
      idle(2);
      send_slot(1'b0, 32'h3333, 32'h2222, 16, 16, 8, 16);
      send_slot(1'b1, 32'h4444, 32'h3333, 16, 16, 0, 16);
      send_frames(1, 32'h5555, 32'h6666, 32'h4444, 16, 16);
      send_tail(32'h6666, 16, 16);
      n_cmp++;
      if (pq.size() != 2) begin
         n_fail++;
         $display("FAIL rst_post_count: got %0d, required 2", pq.size());
      end else begin
         n_cmp++;
         if (pq[0] !== {16'h0000, 16'h4444}) begin
            n_fail++;
            $display("FAIL rst_post_first: got %h, required 00004444", pq[0]);
         end
         n_cmp++;
         if (pq[1] !== {16'h5555, 16'h6666}) begin
            n_fail++;
            $display("FAIL rst_post_second: got %h, required 55556666", pq[1]);
         end
      end
   endtask

   task automatic test_phase_sweep();
      int          ph[4]   = '{1, 3, 6, 8};
      logic [15:0] lv[4]   = '{16'h1357, 16'hF00D, 16'h8001, 16'h0F0F};
      logic [15:0] rv[4]   = '{16'h2468, 16'hBEEF, 16'h7FFE, 16'hF0F0};
      int bad_data, bad_per, bad_high;
      for (int p = 0; p < 4; p++) begin
         phase = ph[p];
         do_reset();
         send_frames(25, {16'h0, lv[p]}, {16'h0, rv[p]}, {16'h0, rv[p]}, 16, 32);
         send_tail({16'h0, rv[p]}, 16, 32);
         bad_data = 0;
         bad_per  = 0;
         bad_high = 0;
         for (int i = 0; i < pq.size(); i++)
            if (pq[i] !== {(i == 0) ? 16'h0000 : lv[p], rv[p]}) bad_data++;
         foreach (periods[i]) if (periods[i] != 256) bad_per++;
         foreach (highs[i]) if (highs[i] < 126 || highs[i] > 130) bad_high++;
         n_cmp++;
         if (pq.size() != 25) begin
            n_fail++;
            $display("FAIL sweep_ph%0d_count: got %0d pulses, required 25", ph[p], pq.size());
         end
         n_cmp++;
         if (bad_data != 0) begin
            n_fail++;
            $display("FAIL sweep_ph%0d_data: got %0d bad samples, required 0", ph[p], bad_data);
         end
         n_cmp++;
         if (periods.size() != 24 || bad_per != 0) begin
            n_fail++;
            $display("FAIL sweep_ph%0d_period: got %0d periods %0d off, required 24 of 256 clk",
                     ph[p], periods.size(), bad_per);
         end
         n_cmp++;
         if (highs.size() != 24 || bad_high != 0) begin
            n_fail++;
            $display("FAIL sweep_ph%0d_duty: got %0d highs %0d off, required 24 within 126..130 clk",
                     ph[p], highs.size(), bad_high);
         end
      end
      phase = 2;
   endtask

   initial begin
      test_reset();
      test_frames16();
      test_slot24();
      test_short12();
      test_midword();
      test_rst_midword();
      test_phase_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
